// File: rtl/offload_pipe_if.sv
// -----------------------------------------------------------------------------
// offload_pipe_if
// Carries one AXI-Stream link (valid/ready/data/keep/last) for offload_pipe.
//   master modport : drives tvalid, tdata, tkeep, tlast; samples tready
//   slave modport  : samples tvalid, tdata, tkeep, tlast; drives tready
// Parameter DATA_W sets the data width; tkeep is DATA_W/8 bits wide.
// -----------------------------------------------------------------------------
interface offload_pipe_if #(
    parameter int DATA_W = 512
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/offload_pipe.sv
// -----------------------------------------------------------------------------
// offload_pipe
// AXI-Stream offload pipeline. Input beats carry NUM_REGS register slots and a
// magic word in slot MAGIC_SLOT. Good beats pass through a PIPELINE_DEPTH-stage
// register pipeline whose stage 1 runs the kernel r0' = r0 + r1; the output beat
// carries the results, the magic word, tkeep all ones and the input tlast.
// A malformed beat inside a packet is turned into a terminator beat
// (tdata=0, tkeep=0, tlast=1) and the rest of that packet is discarded.
//
// Ports:
//   clk        clock
//   reset_n    synchronous active-low reset
//   bypass     (only with OFFLOAD_BYPASS_EN) stage-1 kernel bypass
//   s_axis     input stream (slave modport)
//   m_axis     output stream (master modport)
//   pkt_count  good packets emitted, saturating
//   err_count  malformed beats seen, saturating
//   dbg        {overflow_sticky, S_DISCARD, S_PACKET, S_IDLE}
//
// Optional feature macro: OFFLOAD_BYPASS_EN adds the bypass input.
// -----------------------------------------------------------------------------
module offload_pipe #(
    parameter int                  DATA_W         = 512,
    parameter int                  REG_SIZE       = 32,
    parameter int                  NUM_REGS       = 14,
    parameter int                  MAGIC_SLOT     = 15,
    parameter int                  PIPELINE_DEPTH = 3,
    parameter logic [REG_SIZE-1:0] PKT_MAGIC      = 32'h0FFA0FFB,
    parameter int                  CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef OFFLOAD_BYPASS_EN
    input  logic             bypass,
`endif
    offload_pipe_if.slave    s_axis,
    offload_pipe_if.master   m_axis,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       dbg
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int REGS_W = NUM_REGS * REG_SIZE;
    // Stages 0..MID-1 hold register slots; the final stage holds the formatted beat.
    localparam int MID    = PIPELINE_DEPTH - 1;

    // One-hot encoding so the state maps straight onto dbg[2:0].
    typedef enum logic [2:0] {
        S_IDLE    = 3'b001,
        S_PACKET  = 3'b010,
        S_DISCARD = 3'b100
    } state_t;

    function automatic logic [REGS_W-1:0] kernel(input logic [REGS_W-1:0] regs,
                                                 input logic              pass);
        logic [REGS_W-1:0] res;
        res = regs;
        if (!pass) begin
            res[REG_SIZE-1:0] = regs[REG_SIZE-1:0] + regs[2*REG_SIZE-1:REG_SIZE];
        end else begin
            res[REG_SIZE-1:0] = regs[REG_SIZE-1:0];
        end
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] format_beat(input logic [REGS_W-1:0] regs,
                                                      input logic              term);
        logic [DATA_W-1:0] beat;
        beat = {DATA_W{1'b0}};
        if (!term) begin
            beat[REGS_W-1:0]                          = regs;
            beat[MAGIC_SLOT*REG_SIZE +: REG_SIZE]     = PKT_MAGIC;
        end else begin
            beat = {DATA_W{1'b0}};
        end
        return beat;
    endfunction

    // Returns {saturated, next_value}.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W:0] res;
        if (&cnt) begin
            res = {1'b1, cnt};
        end else begin
            res = {1'b0, cnt + {{(CNT_W-1){1'b0}}, 1'b1}};
        end
        return res;
    endfunction

    state_t              state_r;
    state_t              state_nx_s;
    logic                bypass_s;
    logic                advance_s;
    logic                s_ready_s;
    logic                accept_s;
    logic                good_s;
    logic                load_s;
    logic                load_term_s;
    logic                err_inc_s;
    logic                pkt_inc_s;

    logic [MID-1:0]      valid_r;
    logic [MID-1:0]      last_r;
    logic [MID-1:0]      term_r;
    logic [REGS_W-1:0]   regs_r [0:MID-1];
    logic [REGS_W-1:0]   out_src_s;

    logic                m_valid_r;
    logic                m_last_r;
    logic                m_term_r;
    logic [KEEP_W-1:0]   m_keep_r;
    logic [DATA_W-1:0]   m_data_r;

    logic [CNT_W-1:0]    pkt_count_r;
    logic [CNT_W-1:0]    err_count_r;
    logic [CNT_W-1:0]    pkt_nx_s;
    logic [CNT_W-1:0]    err_nx_s;
    logic                pkt_sat_s;
    logic                err_sat_s;
    logic                ovf_r;

`ifdef OFFLOAD_BYPASS_EN
    assign bypass_s = bypass;
`else
    assign bypass_s = 1'b0;
`endif

    assign advance_s = !m_valid_r || m_axis.tready;
    // Ready is held low while reset is applied; S_DISCARD drains regardless of output.
    assign s_ready_s = reset_n && ((state_r == S_DISCARD) || advance_s);
    assign accept_s  = s_axis.tvalid && s_ready_s;
    assign good_s    = (&s_axis.tkeep) &&
                       (s_axis.tdata[MAGIC_SLOT*REG_SIZE +: REG_SIZE] == PKT_MAGIC);
    assign pkt_inc_s = m_valid_r && m_axis.tready && m_last_r && !m_term_r;

    // Packet FSM: next state and stage-0 load decisions for the accepted beat.
    always_comb begin
        state_nx_s  = state_r;
        load_s      = 1'b0;
        load_term_s = 1'b0;
        err_inc_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept_s && good_s) begin
                    load_s     = 1'b1;
                    state_nx_s = s_axis.tlast ? S_IDLE : S_PACKET;
                end else if (accept_s) begin
                    err_inc_s  = 1'b1;
                    state_nx_s = s_axis.tlast ? S_IDLE : S_DISCARD;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_PACKET: begin
                if (accept_s && good_s) begin
                    load_s     = 1'b1;
                    state_nx_s = s_axis.tlast ? S_IDLE : S_PACKET;
                end else if (accept_s) begin
                    load_s      = 1'b1;
                    load_term_s = 1'b1;
                    err_inc_s   = 1'b1;
                    state_nx_s  = s_axis.tlast ? S_IDLE : S_DISCARD;
                end else begin
                    state_nx_s = S_PACKET;
                end
            end
            S_DISCARD: begin
                if (accept_s && s_axis.tlast) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_DISCARD;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Source for the output stage; with only two stages the kernel runs on the way out.
    always_comb begin
        if (MID == 1) begin
            out_src_s = kernel(regs_r[0], bypass_s);
        end else begin
            out_src_s = regs_r[MID-1];
        end
    end

    // Pipeline control bits: valid/last/term shift together on advance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_r   <= {MID{1'b0}};
            last_r    <= {MID{1'b0}};
            term_r    <= {MID{1'b0}};
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_term_r  <= 1'b0;
            m_keep_r  <= {KEEP_W{1'b0}};
        end else if (advance_s) begin
            valid_r[0] <= load_s;
            last_r[0]  <= load_term_s ? 1'b1 : s_axis.tlast;
            term_r[0]  <= load_term_s;
            for (int i = 1; i < MID; i++) begin
                valid_r[i] <= valid_r[i-1];
                last_r[i]  <= last_r[i-1];
                term_r[i]  <= term_r[i-1];
            end
            m_valid_r <= valid_r[MID-1];
            m_last_r  <= last_r[MID-1];
            m_term_r  <= term_r[MID-1];
            m_keep_r  <= (valid_r[MID-1] && !term_r[MID-1]) ? {KEEP_W{1'b1}} : {KEEP_W{1'b0}};
        end
    end

    // Pipeline data path (not reset); the stage 0 -> 1 move applies the kernel.
    always_ff @(posedge clk) begin
        if (advance_s) begin
            regs_r[0] <= s_axis.tdata[REGS_W-1:0];
            for (int i = 1; i < MID; i++) begin
                regs_r[i] <= (i == 1) ? kernel(regs_r[0], bypass_s) : regs_r[i-1];
            end
            m_data_r <= format_beat(out_src_s, term_r[MID-1]);
        end
    end

    // Saturating next values for the status counters.
    always_comb begin
        if (pkt_inc_s) begin
            {pkt_sat_s, pkt_nx_s} = sat_inc(pkt_count_r);
        end else begin
            {pkt_sat_s, pkt_nx_s} = {1'b0, pkt_count_r};
        end
        if (err_inc_s) begin
            {err_sat_s, err_nx_s} = sat_inc(err_count_r);
        end else begin
            {err_sat_s, err_nx_s} = {1'b0, err_count_r};
        end
    end

    // Status counters and overflow sticky bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pkt_count_r <= {CNT_W{1'b0}};
            err_count_r <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
        end else begin
            pkt_count_r <= pkt_nx_s;
            err_count_r <= err_nx_s;
            ovf_r       <= ovf_r || pkt_sat_s || err_sat_s;
        end
    end

    assign s_axis.tready = s_ready_s;
    assign m_axis.tvalid = m_valid_r;
    assign m_axis.tdata  = m_data_r;
    assign m_axis.tkeep  = m_keep_r;
    assign m_axis.tlast  = m_last_r;
    assign pkt_count     = pkt_count_r;
    assign err_count     = err_count_r;
    assign dbg           = {ovf_r, state_r};

endmodule

// File: tb/tb_offload_pipe.sv
// -----------------------------------------------------------------------------
// tb_offload_pipe
// Self-checking bench for offload_pipe: a reference model predicts output beats
// into a scoreboard queue at input acceptance; a monitor pops and compares them
// at each output handshake. Also checks latency, stall stability, counters, dbg.
// -----------------------------------------------------------------------------
module tb_offload_pipe;

    localparam int DW    = 512;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 3;
    localparam logic [31:0] MAGIC = 32'h0FFA0FFB;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          chk_lat;
        int            acc;
    } sb_t;

    logic          clk;
    logic          reset_n;
    logic          bypass_v;
    logic [15:0]   pkt_count;
    logic [15:0]   err_count;
    logic [3:0]    dbg;

    offload_pipe_if #(.DATA_W(DW)) s_if ();
    offload_pipe_if #(.DATA_W(DW)) m_if ();

    offload_pipe dut (
        .clk       (clk),
        .reset_n   (reset_n),
`ifdef OFFLOAD_BYPASS_EN
        .bypass    (bypass_v),
`endif
        .s_axis    (s_if),
        .m_axis    (m_if),
        .pkt_count (pkt_count),
        .err_count (err_count),
        .dbg       (dbg)
    );

    int        checks = 0;
    int        errors = 0;
    int        cyc    = 0;
    int        mstate = 0;     // 0 idle, 1 packet, 2 discard
    int        exp_pkt = 0;
    int        exp_err = 0;
    logic [3:0] rdy_pat = 4'hF;
    sb_t       sb [$];

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Output ready pattern, one bit per cycle.
    initial begin
        int idx;
        idx = 0;
        m_if.tready = 1'b1;
        forever begin
            @(negedge clk);
            m_if.tready = rdy_pat[idx & 3];
            idx++;
        end
    end

    function automatic logic [DW-1:0] mk_beat(input logic [31:0] s0, input logic [31:0] s1,
                                             input logic [31:0] magic, input int tag);
        logic [DW-1:0] d;
        d = '0;
        for (int i = 2; i < 15; i++) d[i*32 +: 32] = 32'h1000_0000 + 32'(tag * 256 + i);
        d[0 +: 32]     = s0;
        d[32 +: 32]    = s1;
        d[15*32 +: 32] = magic;
        return d;
    endfunction

    function automatic logic [DW-1:0] exp_out(input logic [DW-1:0] d, input logic byp);
        logic [DW-1:0] o;
        o = '0;
        for (int i = 0; i < 14; i++) o[i*32 +: 32] = d[i*32 +: 32];
        if (!byp) o[31:0] = d[31:0] + d[63:32];
        o[15*32 +: 32] = MAGIC;
        return o;
    endfunction

    // Reference model: called when a beat is known to be accepted at the next edge.
    task automatic model_accept(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        logic good;
        logic byp;
        sb_t  e;
        byp = 1'b0;
`ifdef OFFLOAD_BYPASS_EN
        byp = bypass_v;
`endif
        good      = (&k) && (d[15*32 +: 32] == MAGIC);
        e.chk_lat = (rdy_pat == 4'hF);
        e.acc     = cyc + 1;
        if (mstate == 2) begin
            mstate = l ? 0 : 2;
        end else if (good) begin
            e.data = exp_out(d, byp);
            e.keep = '1;
            e.last = l;
            sb.push_back(e);
            if (l) exp_pkt++;
            mstate = l ? 0 : 1;
        end else begin
            exp_err++;
            if (mstate == 1) begin
                e.data = '0;
                e.keep = '0;
                e.last = 1'b1;
                sb.push_back(e);
            end
            mstate = l ? 0 : 2;
        end
    endtask

    // Called at a negedge; returns at the negedge right after acceptance.
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        int n;
        n = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        while (1) begin
            #1;
            if (s_if.tready === 1'b1) begin
                model_accept(d, k, l);
                @(negedge clk);
                break;
            end
            @(negedge clk);
            n++;
            if (n > 200) begin
                check_eq("in_accept_timeout", 512'(s_if.tready), 512'(1));
                break;
            end
        end
        s_if.tvalid = 1'b0;
    endtask

    // bad_kind: 0 = magic zeroed, 1 = partial tkeep; bad_idx < 0 means all good.
    task automatic send_pkt(input int nb, input logic [31:0] s0, input logic [31:0] s1,
                            input int bad_idx, input int bad_kind, input int tag);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        @(negedge clk);
        for (int b = 0; b < nb; b++) begin
            d = mk_beat(s0, s1, MAGIC, tag * 16 + b);
            k = '1;
            if (b == bad_idx && bad_kind == 0) d[15*32 +: 32] = 32'h0;
            if (b == bad_idx && bad_kind == 1) k = 64'hFFFF_0000_0000_0000;
            send_beat(d, k, (b == nb - 1));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        check_eq("drain_empty", 512'(sb.size()), 512'(0));
    endtask

    task automatic check_status(input string tag);
        logic [2:0] st;
        st = 3'b001 << mstate;
        #1;
        check_eq({tag, "_pkt_count"}, 512'(pkt_count), 512'(exp_pkt));
        check_eq({tag, "_err_count"}, 512'(err_count), 512'(exp_err));
        check_eq({tag, "_dbg"}, 512'(dbg), 512'({1'b0, st}));
    endtask

    // Output monitor: samples just before each rising edge.
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic [KW-1:0] prev_keep;
        logic          prev_last;
        sb_t           e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_keep  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (reset_n !== 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_eq("stall_tvalid", 512'(m_if.tvalid), 512'(1));
                    check_eq("stall_tdata", m_if.tdata, prev_data);
                    check_eq("stall_tkeep", 512'(m_if.tkeep), 512'(prev_keep));
                    check_eq("stall_tlast", 512'(m_if.tlast), 512'(prev_last));
                end
                if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
                    check_eq("sb_nonempty", 512'(sb.size() != 0), 512'(1));
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check_eq("out_tdata", m_if.tdata, e.data);
                        check_eq("out_tkeep", 512'(m_if.tkeep), 512'(e.keep));
                        check_eq("out_tlast", 512'(m_if.tlast), 512'(e.last));
                        if (e.chk_lat) check_eq("latency", 512'(cyc + 1 - e.acc), 512'(DEPTH));
                    end
                end
                prev_stall = (m_if.tvalid === 1'b1) && (m_if.tready === 1'b0);
                if (prev_stall) begin
                    prev_data = m_if.tdata;
                    prev_keep = m_if.tkeep;
                    prev_last = m_if.tlast;
                    if (mstate != 2) check_eq("stall_s_tready", 512'(s_if.tready), 512'(0));
                end
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        bypass_v    = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_m_tvalid", 512'(m_if.tvalid), 512'(0));
        check_eq("rst_m_tlast", 512'(m_if.tlast), 512'(0));
        check_eq("rst_m_tkeep", 512'(m_if.tkeep), 512'(0));
        check_eq("rst_s_tready", 512'(s_if.tready), 512'(0));
        check_status("rst");
        reset_n = 1'b1;
        #1;
        check_eq("post_rst_s_tready", 512'(s_if.tready), 512'(1));

        // 4-beat good packet, no backpressure.
        send_pkt(4, 32'd5, 32'd7, -1, 0, 1);
        drain();
        check_status("t1");

        // Same packet with output ready toggling 1,0,0,1.
        rdy_pat = 4'b1001;
        send_pkt(4, 32'd5, 32'd7, -1, 0, 2);
        drain();
        rdy_pat = 4'hF;
        check_status("t2");

        // Bad magic on beat 3 of 5: terminator, then discard.
        send_pkt(5, 32'd11, 32'd22, 2, 0, 3);
        drain();
        check_status("t3");

        // Partial-tkeep single beat, then a good single-beat packet.
        send_pkt(1, 32'd1, 32'd2, 0, 1, 4);
        send_pkt(1, 32'd3, 32'd4, -1, 0, 5);
        drain();
        check_status("t4");

        // Kernel wrap-around.
        send_pkt(1, 32'hFFFF_FFFF, 32'd2, -1, 0, 6);
        drain();
        check_status("t5");

`ifdef OFFLOAD_BYPASS_EN
        bypass_v = 1'b1;
        send_pkt(1, 32'hFFFF_FFFF, 32'd2, -1, 0, 7);
        drain();
        bypass_v = 1'b0;
        check_status("t5_bypass");
`endif

        // Reset mid-packet with two beats in flight.
        send_pkt(2, 32'd9, 32'd1, 9, 0, 8);
        reset_n = 1'b0;
        sb.delete();
        mstate  = 0;
        exp_pkt = 0;
        exp_err = 0;
        #1;
        check_eq("mid_rst_s_tready", 512'(s_if.tready), 512'(0));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("mid_rst_m_tvalid", 512'(m_if.tvalid), 512'(0));
        check_status("mid_rst");
        send_pkt(2, 32'd20, 32'd30, -1, 0, 9);
        drain();
        check_status("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
